// File: rtl/mpu_store_unit.sv
// Store path of the MPU: on a STORE command, walks one matrix register in row-major order.
// Each element goes read -> capture -> valid/ready send, and the block pulses done once at the end.
module mpu_store_unit #(
  parameter int FP               = 32,
  parameter int M                = 2,
  parameter int N                = 2,
  parameter int MATRIX_REGISTERS = 4,
  localparam int RS = $clog2(MATRIX_REGISTERS),
  localparam int MB = $clog2(M),
  localparam int NB = $clog2(N),
  localparam int MD = $clog2(M) + 1,
  localparam int ND = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    op_in,
  input  logic [RS-1:0] reg_sel_in,
  input  logic [MD-1:0] m_dim_in,
  input  logic [ND-1:0] n_dim_in,
  output logic          busy_out,
  output logic          error_out,
  output logic          rd_en_out,
  output logic [RS-1:0] rd_reg_out,
  output logic [MB-1:0] rd_row_out,
  output logic [NB-1:0] rd_col_out,
  input  logic [FP-1:0] rd_data_in,
  output logic          store_valid_out,
  input  logic          store_ready_in,
  output logic [FP-1:0] store_data_out,
  output logic [MB-1:0] store_row_out,
  output logic [NB-1:0] store_col_out,
  output logic          store_last_out,
  output logic          store_done_out
);

  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [2:0] {
    STORE_IDLE,
    STORE_READ,
    STORE_CAPTURE,
    STORE_SEND,
    STORE_DONE
  } state_t;

  state_t        state_q;
  logic [RS-1:0] reg_q;
  logic [MD-1:0] m_q;
  logic [ND-1:0] n_q;
  logic [MB-1:0] row_q, row_d;
  logic [NB-1:0] col_q, col_d;
  logic [FP-1:0] data_q;
  logic          busy_q, error_q, rd_en_q, valid_q, last_q, done_q;

  logic dims_bad;
  logic col_wrap;
  logic elem_last;

  assign dims_bad  = (m_dim_in == '0) || (n_dim_in == '0) ||
                     (m_dim_in > MD'(M)) || (n_dim_in > ND'(N));
  assign col_wrap  = (ND'(col_q) == n_q - ND'(1));
  assign elem_last = (MD'(row_q) == m_q - MD'(1)) && col_wrap;

  // Row-major advance applied on each accepted beat.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_wrap) begin
      col_d = '0;
      row_d = row_q + MB'(1);
    end else begin
      col_d = col_q + NB'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STORE_IDLE;
      reg_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        STORE_IDLE: begin
          error_q <= 1'b0;
          done_q  <= 1'b0;
          if (op_in == OP_STORE) begin
            if (dims_bad) begin
              error_q <= 1'b1;
            end else begin
              reg_q   <= reg_sel_in;
              m_q     <= m_dim_in;
              n_q     <= n_dim_in;
              row_q   <= '0;
              col_q   <= '0;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              state_q <= STORE_READ;
            end
          end
        end
        STORE_READ: begin
          rd_en_q <= 1'b0;
          state_q <= STORE_CAPTURE;
        end
        STORE_CAPTURE: begin
          data_q  <= rd_data_in;
          last_q  <= elem_last;
          valid_q <= 1'b1;
          state_q <= STORE_SEND;
        end
        STORE_SEND: begin
          // Everything presented to the consumer is frozen until the handshake.
          if (store_ready_in) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            row_q   <= row_d;
            col_q   <= col_d;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= STORE_DONE;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= STORE_READ;
            end
          end
        end
        STORE_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= STORE_IDLE;
        end
        default: begin
          state_q <= STORE_IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out        = busy_q;
  assign error_out       = error_q;
  assign rd_en_out       = rd_en_q;
  assign rd_reg_out      = reg_q;
  assign rd_row_out      = row_q;
  assign rd_col_out      = col_q;
  assign store_valid_out = valid_q;
  assign store_data_out  = data_q;
  assign store_row_out   = row_q;
  assign store_col_out   = col_q;
  assign store_last_out  = last_q;
  assign store_done_out  = done_q;

endmodule

// File: doc/mpu_store_unit.md
# mpu_store_unit

Store-side counterpart of the MPU matrix load path. On an `mpu_pkg::STORE` command it reads one matrix register out of the matrix register file, one element at a time in row-major order. It streams each element, tagged with its row and column, to the memory/testbench side over a valid/ready handshake. It sits between the MPU command decoder and the matrix register file read port, mirroring the load path that fills those registers.

## Interface
- `FP`, default 32: element width in bits (`global_defs::FP`).
- `M`, default 2: maximum rows (`global_defs::M`).
- `N`, default 2: maximum columns (`global_defs::N`).
- `MATRIX_REGISTERS`, default 4: number of matrix registers; `RS = $clog2(MATRIX_REGISTERS)`.
- Derived widths: `MB = $clog2(M)`, `NB = $clog2(N)`, `MD = $clog2(M)+1`, `ND = $clog2(N)+1`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_in`  in  2  `mpu_operation_t`; only `STORE` (2'b10) acts, all other codes are ignored.
- `reg_sel_in`  in  RS  source matrix register for the command.
- `m_dim_in`  in  MD  rows to store, legal range 1..M.
- `n_dim_in`  in  ND  columns to store, legal range 1..N.
- `busy_out`  out  1  high in every state except STORE_IDLE.
- `error_out`  out  1  one-cycle pulse when a STORE command is rejected.
- `rd_en_out`  out  1  register file read strobe.
- `rd_reg_out`  out  RS  register file read index.
- `rd_row_out`  out  MB  register file read row.
- `rd_col_out`  out  NB  register file read column.
- `rd_data_in`  in  FP  read data, valid exactly 1 cycle after `rd_en_out`.
- `store_valid_out`  out  1  element available.
- `store_ready_in`  in  1  consumer accepts the element.
- `store_data_out`  out  FP  element value.
- `store_row_out`  out  MB  element row.
- `store_col_out`  out  NB  element column.
- `store_last_out`  out  1  marks the final element of the matrix.
- `store_done_out`  out  1  one-cycle pulse after the last handshake.

## Operation
- States and transitions:
  - STORE_IDLE → STORE_READ when a STORE command is accepted.
  - STORE_READ → STORE_CAPTURE.
  - STORE_CAPTURE → STORE_SEND.
  - STORE_SEND → STORE_READ on a handshake when the element is not the last.
  - STORE_SEND → STORE_DONE on a handshake when the element is the last.
  - STORE_DONE → STORE_IDLE.
- Command acceptance:
  - A command is accepted only in STORE_IDLE with `op_in==STORE`.
  - On acceptance, latch `reg_sel_in`, `m_dim_in` and `n_dim_in`, and clear the row and column counters.
- Command rejection:
  - A STORE with `m_dim_in` or `n_dim_in` equal to 0, `m_dim_in>M`, or `n_dim_in>N` is rejected.
  - On rejection `error_out` pulses for 1 cycle and the block stays in STORE_IDLE.
- A STORE seen while busy is ignored: no error, no effect.
- STORE_READ: `rd_en_out=1`; `rd_reg_out`, `rd_row_out` and `rd_col_out` come from the latched register and the counters.
- STORE_CAPTURE: `rd_data_in` is registered into the output buffer at the end of the cycle.
- STORE_SEND:
  - `store_valid_out=1`.
  - Data, row, col and last are held stable until `store_valid_out && store_ready_in`.
  - `store_last_out=1` iff row==m_dim-1 and col==n_dim-1.
- Counter advance on each handshake: col increments; when col==n_dim-1, col resets to 0 and row increments.
- STORE_DONE: `store_done_out=1` for 1 cycle.
- Reset values (asserted `rst_n`, including mid-operation): state STORE_IDLE, all outputs 0, counters and buffer 0. A partially sent matrix is abandoned with no done pulse.

## Timing
- Cycle numbering: the command is sampled at the edge ending cycle 0.
- Per-element sequence:
  - Cycle 1: STORE_READ, `rd_en_out=1`, `busy_out=1`.
  - Cycle 2: STORE_CAPTURE, `rd_data_in` valid.
  - Cycle 3: `store_valid_out=1`.
- Per-element cost is 3 cycles plus any ready stall. The next STORE_READ follows the handshake cycle directly.
- `store_done_out` is asserted the cycle after the last handshake.
- `busy_out` falls the cycle after `store_done_out`. A new STORE is accepted in the cycle `busy_out` is 0.
- `error_out` is asserted the cycle after the rejected command is sampled.
- `rd_en_out` and `store_valid_out` are never high in the same cycle.

## Test plan
- Full store, ready tied high:
  - Stimulus: reg 2 holds {1.0, 2.0, 3.0, 4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000); STORE reg=2, m=2, n=2.
  - Response: 4 beats at cycles 3, 6, 9, 12 with (row,col) = (0,0), (0,1), (1,0), (1,1) and matching data.
  - Response: `store_last_out` only on (1,1); done pulse at cycle 13; busy low at cycle 14.
- Backpressure:
  - Stimulus: as above, with `store_ready_in` low for 5 cycles during beat 0.
  - Response: data, row and col stay stable while stalled; no `rd_en_out` during the stall; beat 1 is read the cycle after the handshake.
- Partial dims: STORE m=1, n=2 → 2 beats, (0,0) and (0,1); last on (0,1); row 1 is never read.
- Illegal dims:
  - STORE with m=0 → `error_out` pulse, `busy_out` stays 0, no `rd_en_out`.
  - STORE with n=3 → same response.
- Ignored commands: LOAD and NOP in idle produce no activity; a STORE issued mid-transfer leaves the current sequence and `rd_reg_out` unchanged.
- Reset mid-transfer:
  - Stimulus: assert `rst_n` low during beat 1.
  - Response: all outputs 0 immediately, no done pulse, and a new STORE after release restarts at (0,0).
